// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single RAM port.
// Data wins ties; each access ends in one hit pulse, aborting with ERRWORD after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramack,
    output logic        err
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {Idle, Dacc, Iacc, Dresp, Iresp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       store_q, store_d;
    logic              wflag_q, wflag_d;
    logic [31:0]       iload_q, iload_d;
    logic [31:0]       dload_q, dload_d;
    logic              err_q, err_d;
    logic              timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= Idle;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wflag_q <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wflag_q <= wflag_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        addr_d   = addr_q;
        store_d  = store_q;
        wflag_d  = wflag_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            Idle: begin
                if (dREN || dWEN) begin
                    state_d = Dacc;
                    addr_d  = daddr;
                    store_d = dstore;
                    wflag_d = dWEN;
                end else if (iREN) begin
                    state_d = Iacc;
                    addr_d  = iaddr;
                    wflag_d = 1'b0;
                end
            end
            Dacc: begin
                ramREN   = ~wflag_q;
                ramWEN   = wflag_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                // An ack arriving on the timeout cycle still completes normally.
                if (ramack) begin
                    if (!wflag_q) dload_d = ramload;
                    state_d = Dresp;
                end else if (timeout) begin
                    if (!wflag_q) dload_d = ERRWORD;
                    err_d   = 1'b1;
                    state_d = Dresp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            Iacc: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (ramack) begin
                    iload_d = ramload;
                    state_d = Iresp;
                end else if (timeout) begin
                    iload_d = ERRWORD;
                    err_d   = 1'b1;
                    state_d = Iresp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            // Response states never accept a request, so a still-held one waits for Idle.
            Dresp:   state_d = Idle;
            Iresp:   state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    assign ihit  = (state_q == Iresp);
    assign dhit  = (state_q == Dresp);
    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: read, contention, held request,
// timeout, ack-at-boundary and asynchronous reset mid-access.
module tb_mem_arbiter;

    localparam int unsigned TO = 16;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN, ramack;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int fails  = 0;

    mem_arbiter #(.TIMEOUT(TO), .ERRWORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramack(ramack), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0; ramack = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        tick(); tick();
        checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000", {ihit, dhit, ramREN, ramWEN, err});
        end
        checks++;
        if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
            fails++;
            $display("FAIL reset_words: got %h %h %h %h want all 0", iload, dload, ramaddr, ramstore);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_read();
        dREN = 1; daddr = 32'h40;
        tick();
        checks++;
        if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin
            fails++;
            $display("FAIL read_dacc: got ren/wen=%b addr=%h want 10 00000040", {ramREN, ramWEN}, ramaddr);
        end
        tick();
        checks++;
        if (ramREN !== 1'b1 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL read_wait: got ramREN=%b dhit=%b want 1 0", ramREN, dhit);
        end
        ramack = 1; ramload = 32'h1234;
        tick();
        checks++;
        if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h1234) begin
            fails++;
            $display("FAIL read_hit: got dhit=%b ihit=%b dload=%h want 1 0 00001234", dhit, ihit, dload);
        end
        dREN = 0; ramack = 0;
        tick();
        checks++;
        if (dhit !== 1'b0 || ramREN !== 1'b0 || dload !== 32'h1234) begin
            fails++;
            $display("FAIL read_idle: got dhit=%b ramREN=%b dload=%h want 0 0 00001234", dhit, ramREN, dload);
        end
    endtask

    task automatic test_contention();
        iREN = 1; iaddr = 32'h100;
        dWEN = 1; daddr = 32'h80; dstore = 32'hCAFE;
        tick();
        checks++;
        if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h80 || ramstore !== 32'hCAFE) begin
            fails++;
            $display("FAIL cont_write: got ren/wen=%b addr=%h store=%h want 01 00000080 0000cafe",
                     {ramREN, ramWEN}, ramaddr, ramstore);
        end
        ramack = 1; ramload = 32'hDEAD;
        tick();
        checks++;
        if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h1234) begin
            fails++;
            $display("FAIL cont_dhit: got dhit=%b ihit=%b dload=%h want 1 0 00001234", dhit, ihit, dload);
        end
        dWEN = 0; ramack = 0;
        tick();
        checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0) begin
            fails++;
            $display("FAIL cont_idle: got %b want 0000", {ihit, dhit, ramREN, ramWEN});
        end
        tick();
        checks++;
        if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100 || ramstore !== 32'h0) begin
            fails++;
            $display("FAIL cont_iacc: got ren/wen=%b addr=%h store=%h want 10 00000100 0",
                     {ramREN, ramWEN}, ramaddr, ramstore);
        end
        ramack = 1; ramload = 32'hBEEF;
        tick();
        checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'hBEEF) begin
            fails++;
            $display("FAIL cont_ihit: got ihit=%b dhit=%b iload=%h want 1 0 0000beef", ihit, dhit, iload);
        end
        iREN = 0; ramack = 0;
        tick();
    endtask

    task automatic test_held_request();
        logic [3:0] hits;
        logic [3:0] strobes;
        iREN = 1; iaddr = 32'h200; ramack = 1; ramload = 32'h77;
        // Expected per cycle: IACC, IRESP, IDLE, IACC
        for (int i = 0; i < 4; i++) begin
            tick();
            hits[i]    = ihit;
            strobes[i] = ramREN;
        end
        checks++;
        if (hits !== 4'b0010) begin
            fails++;
            $display("FAIL held_ihit: got %b want 0010", hits);
        end
        checks++;
        if (strobes !== 4'b1001) begin
            fails++;
            $display("FAIL held_strobe: got %b want 1001", strobes);
        end
        tick();
        checks++;
        if (ihit !== 1'b1 || iload !== 32'h77) begin
            fails++;
            $display("FAIL held_second: got ihit=%b iload=%h want 1 00000077", ihit, iload);
        end
        iREN = 0; ramack = 0;
        tick();
        checks++;
        if (ihit !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL held_end: got ihit=%b err=%b want 0 0", ihit, err);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        dREN = 1; daddr = 32'h44; ramack = 0;
        tick();
        for (int i = 0; i < TO; i++) begin
            if (ramREN !== 1'b1 || dhit !== 1'b0) early++;
            tick();
        end
        checks++;
        if (early !== 0) begin
            fails++;
            $display("FAIL to_wait: got %0d bad DACC cycles want 0", early);
        end
        checks++;
        if (dhit !== 1'b1 || dload !== 32'hBAD1BAD1 || err !== 1'b1) begin
            fails++;
            $display("FAIL to_hit: got dhit=%b dload=%h err=%b want 1 bad1bad1 1", dhit, dload, err);
        end
        dREN = 0;
        tick();
        checks++;
        if (dhit !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky: got dhit=%b err=%b want 0 1", dhit, err);
        end
        // A later successful read leaves err set.
        dREN = 1; daddr = 32'h4C;
        tick();
        ramack = 1; ramload = 32'h66;
        tick();
        checks++;
        if (dhit !== 1'b1 || dload !== 32'h66 || err !== 1'b1) begin
            fails++;
            $display("FAIL to_after: got dhit=%b dload=%h err=%b want 1 00000066 1", dhit, dload, err);
        end
        dREN = 0; ramack = 0;
        tick();
    endtask

    task automatic test_ack_boundary();
        nRST = 0;
        #2;
        checks++;
        if (err !== 1'b0 || dload !== 32'h0) begin
            fails++;
            $display("FAIL bnd_reset: got err=%b dload=%h want 0 0", err, dload);
        end
        nRST = 1;
        tick();
        dREN = 1; daddr = 32'h48;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        checks++;
        if (ramREN !== 1'b1 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL bnd_last: got ramREN=%b dhit=%b want 1 0", ramREN, dhit);
        end
        ramack = 1; ramload = 32'h55;
        tick();
        checks++;
        if (dhit !== 1'b1 || dload !== 32'h55 || err !== 1'b0) begin
            fails++;
            $display("FAIL bnd_hit: got dhit=%b dload=%h err=%b want 1 00000055 0", dhit, dload, err);
        end
        dREN = 0; ramack = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        iREN = 1; iaddr = 32'h300;
        tick();
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
            fails++;
            $display("FAIL rst_iacc: got ramREN=%b addr=%h want 1 00000300", ramREN, ramaddr);
        end
        #2 nRST = 0;
        #1;
        checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0 || {ramaddr, ramstore, iload, dload} !== 128'h0) begin
            fails++;
            $display("FAIL rst_async: got flags=%b addr=%h store=%h iload=%h dload=%h want all 0",
                     {ihit, dhit, ramREN, ramWEN, err}, ramaddr, ramstore, iload, dload);
        end
        @(negedge CLK);
        nRST = 1;
        tick();
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300 || ihit !== 1'b0) begin
            fails++;
            $display("FAIL rst_restart: got ramREN=%b addr=%h ihit=%b want 1 00000300 0", ramREN, ramaddr, ihit);
        end
        ramack = 1; ramload = 32'h99;
        tick();
        checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h99) begin
            fails++;
            $display("FAIL rst_ihit: got ihit=%b dhit=%b iload=%h want 1 0 00000099", ihit, dhit, iload);
        end
        iREN = 0; ramack = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_contention();
        test_held_request();
        test_timeout();
        test_ack_boundary();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
